text_console_writer: RTL and testbench

TEXT_CONSOLE_WRITER -- requirements
Module: text_console_writer

---
 rtl/text_console_writer_if.sv | 23 ++
 rtl/text_console_writer.sv | 164 ++++++++++++++++
 tb/tb_text_console_writer.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/text_console_writer_if.sv
// Character-stream producer and text-RAM write port of the console writer.
// The slave side is the writer; the master side is whoever feeds it bytes.
interface text_console_writer_if;
    logic [7:0]  ch_data;
    logic        ch_valid;
    logic        ch_ready;
    logic [10:0] mem_addr;
    logic [7:0]  mem_data;
    logic        mem_wren;
    logic [5:0]  cursor_x;
    logic [4:0]  cursor_y;
    logic        busy;

    modport master (
        output ch_data, ch_valid,
        input  ch_ready, mem_addr, mem_data, mem_wren, cursor_x, cursor_y, busy
    );

    modport slave (
        input  ch_data, ch_valid,
        output ch_ready, mem_addr, mem_data, mem_wren, cursor_x, cursor_y, busy
    );
endinterface

// File: rtl/text_console_writer.sv
// ASCII stream to 64x24 glyph-index text RAM writer with cursor handling,
// full-screen clear on reset/form-feed and per-row clear on line advance.
module text_console_writer #(
    parameter int COLS  = 64,
    parameter int ROWS  = 24,
    parameter int DEPTH = 1536
) (
    input  logic                  CLOCK_50,
    input  logic                  RESET,
    text_console_writer_if.slave  bus
);

    typedef enum logic [1:0] {
        CLEAR  = 2'd0,
        IDLE   = 2'd1,
        ROWCLR = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [10:0] cnt_reg, cnt_next;
    logic [5:0]  x_reg, x_next;
    logic [4:0]  y_reg, y_next;
    logic [10:0] addr_reg, addr_next;
    logic [7:0]  data_reg, data_next;
    logic        wren_reg, wren_next;

    logic [4:0]  glyph_lut [256];
    logic [4:0]  y_adv;
    logic        is_print;

    // Byte-to-glyph table: letters of either case map to 1..26, all else 0.
    generate
        for (genvar gi = 0; gi < 256; gi++) begin : g_glyph
            if (gi >= 65 && gi <= 90) begin : g_upper
                assign glyph_lut[gi] = 5'(gi - 64);
            end else if (gi >= 97 && gi <= 122) begin : g_lower
                assign glyph_lut[gi] = 5'(gi - 96);
            end else begin : g_other
                assign glyph_lut[gi] = 5'd0;
            end
        end
    endgenerate

    assign y_adv    = (y_reg == 5'(ROWS - 1)) ? 5'd0 : y_reg + 5'd1;
    assign is_print = (bus.ch_data >= 8'h20) && (bus.ch_data <= 8'h7E);

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            state_reg <= CLEAR;
            cnt_reg   <= 11'd0;
            x_reg     <= 6'd0;
            y_reg     <= 5'd0;
            addr_reg  <= 11'd0;
            data_reg  <= 8'd0;
            wren_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            x_reg     <= x_next;
            y_reg     <= y_next;
            addr_reg  <= addr_next;
            data_reg  <= data_next;
            wren_reg  <= wren_next;
        end
    end

    // Both clear states issue one write per count and spend one extra
    // write-free cycle at the terminal count before handing back to IDLE.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        x_next     = x_reg;
        y_next     = y_reg;
        addr_next  = addr_reg;
        data_next  = 8'd0;
        wren_next  = 1'b0;

        case (state_reg)
            CLEAR: begin
                if (cnt_reg < 11'(DEPTH)) begin
                    wren_next = 1'b1;
                    addr_next = cnt_reg;
                    cnt_next  = cnt_reg + 11'd1;
                end else begin
                    state_next = IDLE;
                    cnt_next   = 11'd0;
                    x_next     = 6'd0;
                    y_next     = 5'd0;
                end
            end

            ROWCLR: begin
                if (cnt_reg < 11'(COLS)) begin
                    wren_next = 1'b1;
                    addr_next = {y_reg, cnt_reg[5:0]};
                    cnt_next  = cnt_reg + 11'd1;
                end else begin
                    state_next = IDLE;
                    cnt_next   = 11'd0;
                end
            end

            IDLE: begin
                if (bus.ch_valid) begin
                    if (is_print) begin
                        wren_next = 1'b1;
                        addr_next = {y_reg, x_reg};
                        data_next = {3'd0, glyph_lut[bus.ch_data]};
                        if (x_reg == 6'(COLS - 1)) begin
                            x_next     = 6'd0;
                            y_next     = y_adv;
                            state_next = ROWCLR;
                            cnt_next   = 11'd0;
                        end else begin
                            x_next = x_reg + 6'd1;
                        end
                    end else begin
                        case (bus.ch_data)
                            8'h0A: begin
                                // LF has no glyph, so its first row-clear
                                // write goes out on the accept edge itself.
                                x_next     = 6'd0;
                                y_next     = y_adv;
                                wren_next  = 1'b1;
                                addr_next  = {y_adv, 6'd0};
                                state_next = ROWCLR;
                                cnt_next   = 11'd1;
                            end
                            8'h0D: x_next = 6'd0;
                            8'h08: begin
                                if (x_reg != 6'd0) begin
                                    x_next    = x_reg - 6'd1;
                                    wren_next = 1'b1;
                                    addr_next = {y_reg, x_reg - 6'd1};
                                end
                            end
                            8'h0C: begin
                                x_next     = 6'd0;
                                y_next     = 5'd0;
                                state_next = CLEAR;
                                cnt_next   = 11'd0;
                            end
                            default: ;
                        endcase
                    end
                end
            end

            default: begin
                state_next = CLEAR;
                cnt_next   = 11'd0;
            end
        endcase
    end

    assign bus.ch_ready = (state_reg == IDLE);
    assign bus.busy     = (state_reg == CLEAR) || (state_reg == ROWCLR);
    assign bus.mem_addr = addr_reg;
    assign bus.mem_data = data_reg;
    assign bus.mem_wren = wren_reg;
    assign bus.cursor_x = x_reg;
    assign bus.cursor_y = y_reg;

endmodule

// File: tb/tb_text_console_writer.sv
// Directed bench for text_console_writer: clears, glyph writes, control
// bytes, line-advance row clears and reset aborting a clear.
module tb_text_console_writer;

    logic CLOCK_50;
    logic RESET;
    int   checks;
    int   errors;

    text_console_writer_if bus ();

    text_console_writer #(.COLS(64), .ROWS(24), .DEPTH(1536)) dut (
        .CLOCK_50 (CLOCK_50),
        .RESET    (RESET),
        .bus      (bus)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (bus.ch_ready !== 1'b1 && n < 4000) begin
            @(negedge CLOCK_50);
            n++;
        end
        check("ready_wait", {31'd0, bus.ch_ready}, 32'd1);
    endtask

    // Returns at the negedge of the cycle following the accept edge.
    task automatic send_byte(input logic [7:0] b);
        wait_ready();
        bus.ch_data  = b;
        bus.ch_valid = 1'b1;
        @(negedge CLOCK_50);
        bus.ch_valid = 1'b0;
        $display("tx byte=%02h -> wren=%0d addr=%0d data=%0d cursor=(%0d,%0d)",
                 b, bus.mem_wren, bus.mem_addr, bus.mem_data, bus.cursor_x, bus.cursor_y);
    endtask

    task automatic check_clear_sweep(input string tag);
        int bad = 0;
        for (int i = 0; i < 1536; i++) begin
            @(negedge CLOCK_50);
            if (bus.mem_wren !== 1'b1 || bus.mem_addr !== 11'(i) ||
                bus.mem_data !== 8'd0 || bus.ch_ready !== 1'b0 || bus.busy !== 1'b1)
                bad++;
        end
        check({tag, "_writes_bad"}, bad, 0);
        @(negedge CLOCK_50);
        check({tag, "_ready_after"}, {31'd0, bus.ch_ready}, 32'd1);
        check({tag, "_wren_after"}, {31'd0, bus.mem_wren}, 32'd0);
        check({tag, "_cursor"}, {21'd0, bus.cursor_y, bus.cursor_x}, 32'd0);
        $display("clear sweep %s done", tag);
    endtask

    // Starts on the cycle carrying the first row write; ends one cycle past the last.
    task automatic check_row_sweep(input string tag, input int base);
        int bad = 0;
        for (int i = 0; i < 64; i++) begin
            if (bus.mem_wren !== 1'b1 || bus.mem_addr !== 11'(base + i) ||
                bus.mem_data !== 8'd0 || bus.ch_ready !== 1'b0)
                bad++;
            @(negedge CLOCK_50);
        end
        check({tag, "_row_bad"}, bad, 0);
        check({tag, "_ready_back"}, {31'd0, bus.ch_ready}, 32'd1);
        check({tag, "_wren_idle"}, {31'd0, bus.mem_wren}, 32'd0);
        $display("row sweep %s base=%0d done", tag, base);
    endtask

    logic [7:0] hi_str [3] = '{8'h48, 8'h69, 8'h21};
    logic [7:0] hi_glyph [3] = '{8'd8, 8'd9, 8'd0};
    logic [7:0] held [3] = '{8'h0D, 8'h07, 8'hFF};

    initial begin
        checks       = 0;
        errors       = 0;
        RESET        = 1'b1;
        bus.ch_data  = 8'h00;
        bus.ch_valid = 1'b0;

        // Reset state
        @(negedge CLOCK_50);
        check("rst_wren",  {31'd0, bus.mem_wren}, 32'd0);
        check("rst_addr",  {21'd0, bus.mem_addr}, 32'd0);
        check("rst_data",  {24'd0, bus.mem_data}, 32'd0);
        check("rst_ready", {31'd0, bus.ch_ready}, 32'd0);
        check("rst_busy",  {31'd0, bus.busy}, 32'd1);
        check("rst_cursor", {21'd0, bus.cursor_y, bus.cursor_x}, 32'd0);
        @(negedge CLOCK_50);
        RESET = 1'b0;
        check_clear_sweep("init");

        // "Hi!" streamed with CH_VALID held high
        bus.ch_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.ch_data = hi_str[i];
            @(negedge CLOCK_50);
            check("hi_wren",  {31'd0, bus.mem_wren}, 32'd1);
            check("hi_addr",  {21'd0, bus.mem_addr}, 32'(i));
            check("hi_data",  {24'd0, bus.mem_data}, {24'd0, hi_glyph[i]});
            check("hi_ready", {31'd0, bus.ch_ready}, 32'd1);
            $display("tx byte=%02h -> addr=%0d data=%0d", hi_str[i], bus.mem_addr, bus.mem_data);
        end
        bus.ch_valid = 1'b0;
        check("hi_x", {26'd0, bus.cursor_x}, 32'd3);
        check("hi_y", {27'd0, bus.cursor_y}, 32'd0);

        // CR returns to column 0 without writing
        send_byte(8'h0D);
        check("cr_wren", {31'd0, bus.mem_wren}, 32'd0);
        check("cr_x", {26'd0, bus.cursor_x}, 32'd0);

        // LF: clear of row 1 at N+1..N+64, ready at N+65
        send_byte(8'h0A);
        check("lf_cursor", {21'd0, bus.cursor_y, bus.cursor_x}, {21'd0, 5'd1, 6'd0});
        check_row_sweep("lf", 64);
        send_byte(8'h0A);

        // BS at column 0 does nothing
        wait_ready();
        send_byte(8'h08);
        check("bs0_wren", {31'd0, bus.mem_wren}, 32'd0);
        check("bs0_cursor", {21'd0, bus.cursor_y, bus.cursor_x}, {21'd0, 5'd2, 6'd0});

        for (int i = 0; i < 5; i++) send_byte(8'h61);
        check("a5_cursor", {21'd0, bus.cursor_y, bus.cursor_x}, {21'd0, 5'd2, 6'd5});
        send_byte(8'h08);
        check("bs_wren", {31'd0, bus.mem_wren}, 32'd1);
        check("bs_addr", {21'd0, bus.mem_addr}, 32'd132);
        check("bs_data", {24'd0, bus.mem_data}, 32'd0);
        check("bs_cursor", {21'd0, bus.cursor_y, bus.cursor_x}, {21'd0, 5'd2, 6'd4});

        // CR, BEL, 0xFF held back-to-back: consumed, nothing written
        bus.ch_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.ch_data = held[i];
            @(negedge CLOCK_50);
            check("ctl_wren",  {31'd0, bus.mem_wren}, 32'd0);
            check("ctl_ready", {31'd0, bus.ch_ready}, 32'd1);
            check("ctl_cursor", {21'd0, bus.cursor_y, bus.cursor_x}, {21'd0, 5'd2, 6'd0});
            $display("tx byte=%02h -> wren=%0d", held[i], bus.mem_wren);
        end
        bus.ch_valid = 1'b0;

        // Walk to (63,23)
        for (int i = 0; i < 21; i++) send_byte(8'h0A);
        for (int i = 0; i < 63; i++) send_byte(8'h20);
        check("walk_cursor", {21'd0, bus.cursor_y, bus.cursor_x}, {21'd0, 5'd23, 6'd63});

        // 'Z' at the last cell: glyph, then row 0 clear, wrap to (0,0)
        send_byte(8'h5A);
        check("z_wren", {31'd0, bus.mem_wren}, 32'd1);
        check("z_addr", {21'd0, bus.mem_addr}, 32'd1535);
        check("z_data", {24'd0, bus.mem_data}, 32'd26);
        check("z_ready", {31'd0, bus.ch_ready}, 32'd0);
        check("z_cursor", {21'd0, bus.cursor_y, bus.cursor_x}, 32'd0);
        @(negedge CLOCK_50);
        check_row_sweep("wrap", 0);

        send_byte(8'h7A);
        check("lz_addr", {21'd0, bus.mem_addr}, 32'd0);
        check("lz_data", {24'd0, bus.mem_data}, 32'd26);
        send_byte(8'h6D);
        check("m_addr", {21'd0, bus.mem_addr}, 32'd1);
        check("m_data", {24'd0, bus.mem_data}, 32'd13);
        send_byte(8'h37);
        check("digit_wren", {31'd0, bus.mem_wren}, 32'd1);
        check("digit_data", {24'd0, bus.mem_data}, 32'd0);

        // Walk to (10,4) then form-feed
        for (int i = 0; i < 4; i++) send_byte(8'h0A);
        for (int i = 0; i < 10; i++) send_byte(8'h62);
        check("b10_cursor", {21'd0, bus.cursor_y, bus.cursor_x}, {21'd0, 5'd4, 6'd10});
        send_byte(8'h0C);
        check("ff_wren", {31'd0, bus.mem_wren}, 32'd0);
        check("ff_busy", {31'd0, bus.busy}, 32'd1);
        check("ff_cursor", {21'd0, bus.cursor_y, bus.cursor_x}, 32'd0);
        check_clear_sweep("ff");

        // Reset in the middle of a form-feed clear
        send_byte(8'h0C);
        begin
            int bad = 0;
            for (int i = 0; i < 700; i++) begin
                @(negedge CLOCK_50);
                if (bus.mem_wren !== 1'b1 || bus.mem_addr !== 11'(i)) bad++;
            end
            check("abort_pre_bad", bad, 0);
        end
        RESET = 1'b1;
        #1;
        check("abort_wren", {31'd0, bus.mem_wren}, 32'd0);
        check("abort_addr", {21'd0, bus.mem_addr}, 32'd0);
        check("abort_busy", {31'd0, bus.busy}, 32'd1);
        @(negedge CLOCK_50);
        check("abort_hold_wren", {31'd0, bus.mem_wren}, 32'd0);
        RESET = 1'b0;
        check_clear_sweep("restart");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
